// File: rtl/timestamp_arbiter.sv
// Captures t_common per channel on request and serializes the captured
// timestamps onto one valid/ready stream with round-robin channel selection.
module timestamp_arbiter #(
  parameter int N_CH = 4,
  parameter int TW   = 64,
  localparam int CW  = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [TW-1:0]   t_common,
  input  logic [N_CH-1:0] req,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [TW-1:0]   out_ts,
  output logic [CW-1:0]   out_ch,
  output logic [N_CH-1:0] overflow,
  input  logic [N_CH-1:0] ovf_clr
);

  logic [N_CH-1:0] pending_q, pending_d;
  logic [TW-1:0]   ts_hold_q [N_CH];
  logic [TW-1:0]   ts_hold_d [N_CH];
  logic            out_valid_q, out_valid_d;
  logic [TW-1:0]   out_ts_q, out_ts_d;
  logic [CW-1:0]   out_ch_q, out_ch_d;
  logic [N_CH-1:0] overflow_q, overflow_d;
  logic [CW-1:0]   ptr_q, ptr_d;

  logic            load_s;
  logic            grant_found_s;
  logic            grant_s;
  logic [CW-1:0]   grant_idx_s;
  logic            granted_s;
  logic            drop_s;

  // First set bit of pend at or after ptr, wrapping; returns {found, index}.
  function automatic logic [CW:0] rr_pick(input logic [N_CH-1:0] pend,
                                          input logic [CW-1:0]   ptr);
    logic          found;
    logic [CW-1:0] sel;
    int            idx;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = (int'(ptr) + k) % N_CH;
      if (!found && pend[idx]) begin
        found = 1'b1;
        sel   = CW'(idx);
      end
    end
    return {found, sel};
  endfunction

  // Next-state logic: slot load/grant, per-channel capture, drop and sticky flags.
  always_comb begin
    pending_d   = pending_q;
    ts_hold_d   = ts_hold_q;
    out_valid_d = out_valid_q;
    out_ts_d    = out_ts_q;
    out_ch_d    = out_ch_q;
    overflow_d  = overflow_q;
    ptr_d       = ptr_q;
    granted_s   = 1'b0;
    drop_s      = 1'b0;

    load_s                       = !out_valid_q || out_ready;
    {grant_found_s, grant_idx_s} = rr_pick(pending_q, ptr_q);
    grant_s                      = load_s && grant_found_s;

    if (load_s) begin
      if (grant_s) begin
        out_valid_d = 1'b1;
        out_ts_d    = ts_hold_q[grant_idx_s];
        out_ch_d    = grant_idx_s;
        if (grant_idx_s == CW'(N_CH - 1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = grant_idx_s + CW'(1);
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      out_valid_d = out_valid_q;
    end

    for (int i = 0; i < N_CH; i++) begin
      granted_s = grant_s && (grant_idx_s == CW'(i));
      drop_s    = 1'b0;
      if (granted_s) begin
        pending_d[i] = 1'b0;
      end else begin
        pending_d[i] = pending_q[i];
      end
      // A channel being granted this cycle is free to capture again.
      if (req[i]) begin
        if (!pending_q[i] || granted_s) begin
          ts_hold_d[i] = t_common;
          pending_d[i] = 1'b1;
        end else begin
          drop_s = 1'b1;
        end
      end else begin
        drop_s = 1'b0;
      end
      overflow_d[i] = drop_s | (overflow_q[i] & ~ovf_clr[i]);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= '0;
      ts_hold_q   <= '{default: '0};
      out_valid_q <= 1'b0;
      out_ts_q    <= '0;
      out_ch_q    <= '0;
      overflow_q  <= '0;
      ptr_q       <= '0;
    end else begin
      pending_q   <= pending_d;
      ts_hold_q   <= ts_hold_d;
      out_valid_q <= out_valid_d;
      out_ts_q    <= out_ts_d;
      out_ch_q    <= out_ch_d;
      overflow_q  <= overflow_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ts    = out_ts_q;
  assign out_ch    = out_ch_q;
  assign overflow  = overflow_q;

endmodule

// File: doc/timestamp_arbiter.md
Name: timestamp_arbiter

Overview:
Shares the 64-bit common time base t_common among N_CH sensor channels that request timestamps. Each channel's request is captured at the exact request cycle into a per-channel holding register. A round-robin arbiter then serializes the captured timestamps onto a single valid/ready output stream tagged with the channel index. Sits between the time reference counter and the temporal-alignment buffers.

Parameters:
N_CH, 4, number of requesting sensor channels (2..16)
TW, 64, timestamp width; must match t_common
CW, $clog2(N_CH), channel-index width (derived, not overridable)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
t_common  in  TW  common time base value, sampled every cycle
req  in  N_CH  per-channel capture request; one-cycle pulse per event, level treated as a pulse every cycle
out_valid  out  1  output timestamp valid
out_ready  in  1  downstream accepts when out_valid && out_ready
out_ts  out  TW  captured timestamp
out_ch  out  CW  channel index of out_ts
overflow  out  N_CH  sticky per-channel drop flag
ovf_clr  in  N_CH  per-channel clear of overflow

Behaviour:
- Reset is asynchronous, active-low, clock clk. All of out_valid, out_ts, out_ch, overflow, pending[] and ts_hold[] reset to 0. The round-robin pointer resets to 0, so ch0 has highest priority first.
- Capture: on a cycle where req[i]=1 and channel i is free, ts_hold[i] <= t_common of that same cycle and pending[i] <= 1.
  - "Free" means pending[i]=0, or pending[i] is being granted in this cycle.
  - The captured value is the request-cycle t_common, never the grant-cycle value.
- Drop: req[i]=1 while pending[i]=1 and i is not granted this cycle -> request discarded, ts_hold[i] unchanged, overflow[i] <= 1.
- Output slot: the slot loads when it is empty (out_valid=0) or is being drained (out_valid && out_ready).
  - If a load is possible and any pending[] bit is set, grant the first pending channel searching from ptr upward with wrap.
  - On grant: out_ts <= ts_hold[g], out_ch <= g, out_valid <= 1, pending[g] <= 0, ptr <= (g+1) mod N_CH.
  - If a load is possible but nothing is pending: out_valid <= 0 when drained, otherwise it stays 0.
- Stall: while out_valid && !out_ready, out_ts and out_ch hold stable. No grants occur and pending[] only accumulates.
- Latency: req at cycle n -> pending at n+1 -> out_valid at n+2 with an empty slot and no contention. Back-to-back grants give 1 timestamp per cycle when out_ready=1.
- Request in the grant cycle: req[i] in the same cycle that i is granted is accepted. The new capture sets pending[i] again, and overflow is not set.
- ovf_clr[i] clears overflow[i]. If ovf_clr[i] and a new drop on i occur in the same cycle, set wins.
- No arithmetic on t_common: t_common wrap-around passes through unchanged.
- Asserting rst_n low mid-transfer discards all pending and output data immediately. No partial output after reset release.

Test Plan:
- Single request: t_common counts from 100, req=0001 at t_common=105 -> 2 cycles later out_valid=1, out_ts=105, out_ch=0; with out_ready=1 out_valid drops the next cycle.
- Simultaneous requests: req=1111 at t_common=200, out_ready=1 -> outputs on 4 consecutive cycles with (ch,ts) = (0,200), (1,200), (2,200), (3,200).
- Round-robin fairness: after a grant to ch1, req=0111 all pending -> grant order ch2, ch0, ch1.
- Backpressure and drop: out_ready=0 with ch0 in the slot; req[2] at t=300 then again at t=305.
  - overflow[2]=1 is set.
  - After releasing out_ready, ch2 is delivered with ts=300.
  - ovf_clr[2] then clears the flag.
- Request in the grant cycle: ch1 pending with ts=400; req[1] at t=410 in the cycle ch1 is granted -> outputs ts=400 then ts=410, overflow[1] stays 0.
- Reset mid-operation: pending=1010 and out_valid=1, assert rst_n low for 1 cycle -> out_valid=0, overflow=0, no stale timestamps after release; next req[3] is granted first via ptr=0 search.
